// File: rtl/sram_fifo_loader.sv
`default_nettype none
// ============================================================================
// Module      : sram_fifo_loader
// Description : Upstream feeder for an SRAM FIFO. Deserialises a strobed,
//               MSB-first bit stream into packets of `bits` bits and issues
//               each completed packet as a one-cycle write strobe. Tracks
//               FIFO occupancy from the writes it issues and the FIFO read
//               strobe, and drops any packet that would overflow the FIFO.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock, rising-edge active
//   rst          in   asynchronous active-high reset
//   serialIn     in   serial data bit, MSB first
//   serialValid  in   serialIn is sampled when high
//   frameStart   in   discard any partial packet (resynchronise)
//   readMode     in   copy of the FIFO read strobe
//   writeMode    out  FIFO write strobe, one cycle per accepted packet
//   inputPacket  out  packet to the FIFO, held after the strobe
//   full         out  count == depth
//   empty        out  count == 0
//   count        out  packets reserved or resident in the FIFO
//   overflow     out  sticky, set when a completed packet is dropped
// ============================================================================
module sram_fifo_loader #(
    parameter int bits      = 8,
    parameter int depth     = 8,
    parameter int countBits = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serialIn,
    input  logic                 serialValid,
    input  logic                 frameStart,
    input  logic                 readMode,
    output logic                 writeMode,
    output logic [bits-1:0]      inputPacket,
    output logic                 full,
    output logic                 empty,
    output logic [countBits-1:0] count,
    output logic                 overflow
);

    localparam int                  c_CNT_W = (bits > 1) ? $clog2(bits) : 1;
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(bits - 1);
    localparam logic [c_CNT_W-1:0]  c_ONE   = c_CNT_W'(1);
    localparam logic [countBits-1:0] c_DEPTH = countBits'(depth);
    localparam logic [countBits-1:0] c_CONE  = countBits'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [bits-1:0]        r_shreg;
    logic [bits-1:0]        w_shreg_nxt;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic [c_CNT_W-1:0]     w_bit_cnt_nxt;
    logic [bits-1:0]        r_packet;
    logic [countBits-1:0]   r_count;
    logic [countBits-1:0]   w_count_nxt;
    logic                   r_overflow;

    logic                   w_dec;
    logic                   w_complete;
    logic                   w_accept;
    logic                   w_drop;
    logic [bits-1:0]        w_assembled;

    // Packet as it would look with the current bit shifted in.
    assign w_assembled = {r_shreg[bits-2:0], serialIn};

    // ------------------------------------------------------------------------
    // Next-state / datapath decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_dec         = readMode && (r_count != '0);
        // frameStart forces bitCnt to 0 before this edge's bit is counted,
        // so a bit arriving together with frameStart can never complete.
        w_complete    = serialValid && !frameStart && (r_bit_cnt == c_LAST);
        // A simultaneous read frees the slot this write needs.
        w_accept      = w_complete && ((r_count < c_DEPTH) || w_dec);
        w_drop        = w_complete && !w_accept;

        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;

        if (frameStart) begin
            if (serialValid) begin
                w_shreg_nxt   = {{(bits-1){1'b0}}, serialIn};
                w_bit_cnt_nxt = c_ONE;
            end else begin
                w_shreg_nxt   = '0;
                w_bit_cnt_nxt = '0;
            end
        end else if (serialValid) begin
            w_shreg_nxt   = w_assembled;
            w_bit_cnt_nxt = w_complete ? '0 : (r_bit_cnt + c_ONE);
        end

        if (w_accept) begin
            w_state_nxt = COMMIT;
        end else if (w_bit_cnt_nxt != '0) begin
            w_state_nxt = SHIFT;
        end else begin
            w_state_nxt = IDLE;
        end

        // Reservation happens on the completion edge, ahead of the write.
        w_count_nxt = r_count;
        if (w_accept && !w_dec) begin
            w_count_nxt = r_count + c_CONE;
        end else if (!w_accept && w_dec) begin
            w_count_nxt = r_count - c_CONE;
        end
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_packet   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_count   <= w_count_nxt;
            if (w_accept) begin
                r_packet <= w_assembled;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign writeMode   = (r_state == COMMIT);
    assign inputPacket = r_packet;
    assign count       = r_count;
    assign full        = (r_count == c_DEPTH);
    assign empty       = (r_count == '0);
    assign overflow    = r_overflow;

endmodule
`default_nettype wire
